// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a master and the register slave.
// The signal names are the AXI port names used by the register slave.
interface axi4_lite_reg_slave_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16
);
  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                  S_AXI_AWPROT;
  logic                        S_AXI_AWVALID;
  logic                        S_AXI_AWREADY;
  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                        S_AXI_WVALID;
  logic                        S_AXI_WREADY;
  logic [1:0]                  S_AXI_BRESP;
  logic                        S_AXI_BVALID;
  logic                        S_AXI_BREADY;
  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                  S_AXI_ARPROT;
  logic                        S_AXI_ARVALID;
  logic                        S_AXI_ARREADY;
  logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                  S_AXI_RRESP;
  logic                        S_AXI_RVALID;
  logic                        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register slave: register 0 is a read-only status word, the rest
// are byte-strobed R/W control registers. One write and one read in flight.
module axi4_lite_reg_slave #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int NUM_REGS       = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  axi4_lite_reg_slave_if.slave               s_axi,
  input  logic [AXI_DATA_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]                wr_strobe,
  output logic [4:0]                         dbg_state
);
  localparam int DW  = AXI_DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int OFF = $clog2(SW);
  localparam int IW  = $clog2(NUM_REGS);
  localparam int HI  = OFF + IW;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // VALID and READY are both high; VALID never waits on READY, and all READY /
  // VALID outputs come straight from flops.

  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} rd_state_t;

  logic [DW-1:0] regs [NUM_REGS];

  // Write path state
  logic                      wr_live;
  logic                      aw_full;
  logic                      w_full;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [DW-1:0]             w_data_q;
  logic [SW-1:0]             w_strb_q;
  logic                      bvalid;
  logic [1:0]                bresp;

  logic                      awready;
  logic                      wready;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      b_hs;
  logic                      commit;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_eff;
  logic [DW-1:0]             w_data_eff;
  logic [SW-1:0]             w_strb_eff;
  logic [IW-1:0]             w_idx;
  logic                      w_in_range;

  assign awready = wr_live & ~aw_full & ~bvalid;
  assign wready  = wr_live & ~w_full & ~bvalid;
  assign aw_hs   = awready & s_axi.S_AXI_AWVALID;
  assign w_hs    = wready & s_axi.S_AXI_WVALID;
  assign b_hs    = bvalid & s_axi.S_AXI_BREADY;
  // Commit on the edge that completes the later of the AW and W handshakes.
  assign commit  = (aw_hs | aw_full) & (w_hs | w_full);

  assign w_addr_eff = aw_full ? aw_addr_q : s_axi.S_AXI_AWADDR;
  assign w_data_eff = w_full ? w_data_q : s_axi.S_AXI_WDATA;
  assign w_strb_eff = w_full ? w_strb_q : s_axi.S_AXI_WSTRB;
  assign w_idx      = w_addr_eff[OFF +: IW];
  assign w_in_range = (w_addr_eff >> HI) == '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_live   <= 1'b0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      wr_strobe <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_live   <= 1'b1;
      wr_strobe <= '0;
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= w_in_range ? RESP_OKAY : RESP_SLVERR;
        if (w_in_range && (w_idx != '0)) wr_strobe[w_idx] <= 1'b1;
        // Register 0 is the status word and is never written.
        for (int k = 1; k < NUM_REGS; k++) begin
          for (int b = 0; b < SW; b++) begin
            if (w_in_range && (w_idx == IW'(k)) && w_strb_eff[b])
              regs[k][b*8 +: 8] <= w_data_eff[b*8 +: 8];
          end
        end
      end else begin
        if (aw_hs) begin
          aw_full   <= 1'b1;
          aw_addr_q <= s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_full   <= 1'b1;
          w_data_q <= s_axi.S_AXI_WDATA;
          w_strb_q <= s_axi.S_AXI_WSTRB;
        end
      end
      if (b_hs) bvalid <= 1'b0;
    end
  end

  // Read path
  rd_state_t     rd_state;
  rd_state_t     rd_next;
  logic          arready;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          ar_hs;
  logic [IW-1:0] r_idx;
  logic          r_in_range;

  assign ar_hs      = arready & s_axi.S_AXI_ARVALID;
  assign r_idx      = s_axi.S_AXI_ARADDR[OFF +: IW];
  assign r_in_range = (s_axi.S_AXI_ARADDR >> HI) == '0;

  always_comb begin
    rd_next = rd_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rd_state)
      R_INIT: rd_next = R_IDLE;
      R_IDLE: begin
        arready = 1'b1;
        if (s_axi.S_AXI_ARVALID) rd_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (s_axi.S_AXI_RREADY) rd_next = R_IDLE;
      end
      default: rd_next = R_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_INIT;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      // Sampled before this edge's write lands, so a colliding read sees old data.
      if (ar_hs) begin
        if (!r_in_range) begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end else begin
          rdata <= (r_idx == '0) ? status_in : regs[r_idx];
          rresp <= RESP_OKAY;
        end
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata;
  assign s_axi.S_AXI_RRESP   = rresp;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DW +: DW] = regs[g];
  end

  assign dbg_state = {rd_state, aw_full, w_full, bvalid};

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         w_addr_eff[OFF-1:0], s_axi.S_AXI_ARADDR[OFF-1:0]};
endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave: reset, strobed writes, status word,
// out-of-range accesses, read/write collision and mid-transaction reset.
module tb_axi4_lite_reg_slave;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NR = 8;

  logic           clk;
  logic           rst;
  logic [DW-1:0]  status_in;
  logic [NR*DW-1:0] regs_out;
  logic [NR-1:0]  wr_strobe;
  logic [4:0]     dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_regs [NR];

  axi4_lite_reg_slave_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) bus ();

  axi4_lite_reg_slave #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axi     (bus.slave),
    .status_in (status_in),
    .regs_out  (regs_out),
    .wr_strobe (wr_strobe),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_fail++;
    $error("FAIL %s: timed out waiting for DUT", tag);
  endtask

  task automatic check_bank(input string tag);
    for (int k = 0; k < NR; k++) check($sformatf("%s_reg%0d", tag, k), regs_out[k*DW +: DW], exp_regs[k]);
  endtask

  // Driver tasks: called just after a falling edge, return just after one.
  task automatic aw_send(input logic [AW-1:0] a);
    int n = 0;
    while (!bus.S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("aw_ready");
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    int n = 0;
    while (!bus.S_AXI_WREADY && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("w_ready");
    bus.S_AXI_WDATA  = d;
    bus.S_AXI_WSTRB  = s;
    bus.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0;
  endtask

  task automatic aw_w_send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    int n = 0;
    while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("aw_w_ready");
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_WVALID  = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
  endtask

  task automatic b_take(input string tag, input logic [1:0] exp_resp);
    int n = 0;
    while (!bus.S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout({tag, "_bvalid"});
    check({tag, "_bresp"}, bus.S_AXI_BRESP, exp_resp);
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    check({tag, "_bvalid_drop"}, bus.S_AXI_BVALID, 1'b0);
    check({tag, "_awready_back"}, bus.S_AXI_AWREADY, 1'b1);
    check({tag, "_wready_back"}, bus.S_AXI_WREADY, 1'b1);
  endtask

  task automatic full_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW/8-1:0] s, input logic [1:0] exp_resp,
                            input logic [NR-1:0] exp_strobe);
    aw_w_send(a, d, s);
    check({tag, "_strobe"}, wr_strobe, exp_strobe);
    check({tag, "_bvalid"}, bus.S_AXI_BVALID, 1'b1);
    check_bank(tag);
    b_take(tag, exp_resp);
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                    input logic [1:0] exp_r);
    int n = 0;
    while (!bus.S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout({tag, "_arready"});
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    check({tag, "_rvalid"}, bus.S_AXI_RVALID, 1'b1);
    check({tag, "_rdata"}, bus.S_AXI_RDATA, exp_d);
    check({tag, "_rresp"}, bus.S_AXI_RRESP, exp_r);
    bus.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0;
    check({tag, "_rvalid_drop"}, bus.S_AXI_RVALID, 1'b0);
    check({tag, "_arready_back"}, bus.S_AXI_ARREADY, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    status_in = '0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    for (int k = 0; k < NR; k++) exp_regs[k] = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_awready", bus.S_AXI_AWREADY, 1'b0);
    check("rst_wready", bus.S_AXI_WREADY, 1'b0);
    check("rst_arready", bus.S_AXI_ARREADY, 1'b0);
    check("rst_bvalid", bus.S_AXI_BVALID, 1'b0);
    check("rst_rvalid", bus.S_AXI_RVALID, 1'b0);
    check("rst_bresp", bus.S_AXI_BRESP, 2'b00);
    check("rst_rresp", bus.S_AXI_RRESP, 2'b00);
    check("rst_rdata", bus.S_AXI_RDATA, 32'h0);
    check("rst_strobe", wr_strobe, 8'h00);
    check_bank("rst");

    rst = 1'b1;
    @(negedge clk);
    check("rel_awready", bus.S_AXI_AWREADY, 1'b1);
    check("rel_wready", bus.S_AXI_WREADY, 1'b1);
    check("rel_arready", bus.S_AXI_ARREADY, 1'b1);
    rd("rel_rd4", 16'h0004, 32'h0000_0000, 2'b00);

    // Strobed write, AW one cycle ahead of W, B held off for 3 cycles
    aw_send(16'h0004);
    check("bb_aw_only_bvalid", bus.S_AXI_BVALID, 1'b0);
    check("bb_aw_only_strobe", wr_strobe, 8'h00);
    check("bb_aw_only_awready", bus.S_AXI_AWREADY, 1'b0);
    w_send(32'hDEAD_BEEF, 4'b0101);
    exp_regs[1] = 32'h00AD_00EF;
    check("bb_strobe", wr_strobe, 8'b0000_0010);
    check("bb_bvalid", bus.S_AXI_BVALID, 1'b1);
    check("bb_bresp", bus.S_AXI_BRESP, 2'b00);
    check_bank("bb");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bb_hold%0d_bvalid", i), bus.S_AXI_BVALID, 1'b1);
      check($sformatf("bb_hold%0d_bresp", i), bus.S_AXI_BRESP, 2'b00);
      check($sformatf("bb_hold%0d_strobe", i), wr_strobe, 8'h00);
    end
    b_take("bb", 2'b00);
    rd("bb_rd", 16'h0004, 32'h00AD_00EF, 2'b00);

    // Upper-byte merge into the same register
    exp_regs[1] = 32'h11AD_33EF;
    full_write("merge", 16'h0004, 32'h1122_3344, 4'b1010, 2'b00, 8'h02);
    // Top register, then just past the end of the bank
    exp_regs[7] = 32'hA5A5_A5A5;
    full_write("top", 16'h001C, 32'hA5A5_A5A5, 4'b1111, 2'b00, 8'h80);
    full_write("oor", 16'h0020, 32'hFFFF_FFFF, 4'b1111, 2'b10, 8'h00);
    rd("oor_rd", 16'h0020, 32'h0, 2'b10);
    rd("top_rd", 16'h001C, 32'hA5A5_A5A5, 2'b00);

    // Status word at register 0
    status_in = 32'h1234_5678;
    rd("st_rd1", 16'h0000, 32'h1234_5678, 2'b00);
    full_write("st_wr", 16'h0000, 32'hFFFF_FFFF, 4'b1111, 2'b00, 8'h00);
    status_in = 32'h9ABC_DEF0;
    rd("st_rd2", 16'h0000, 32'h9ABC_DEF0, 2'b00);

    // Read and write of register 2 on the same edge
    exp_regs[2] = 32'h0000_0011;
    full_write("col_pre", 16'h0008, 32'h0000_0011, 4'b1111, 2'b00, 8'h04);
    bus.S_AXI_ARADDR  = 16'h0008; bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_AWADDR  = 16'h0008; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = 32'h0000_0022; bus.S_AXI_WSTRB = 4'b1111; bus.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    exp_regs[2] = 32'h0000_0022;
    check("col_rvalid", bus.S_AXI_RVALID, 1'b1);
    check("col_rdata_old", bus.S_AXI_RDATA, 32'h0000_0011);
    check("col_bvalid", bus.S_AXI_BVALID, 1'b1);
    check("col_strobe", wr_strobe, 8'h04);
    check_bank("col");
    bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
    check("col_rvalid_drop", bus.S_AXI_RVALID, 1'b0);
    check("col_bvalid_drop", bus.S_AXI_BVALID, 1'b0);
    rd("col_rd_new", 16'h0008, 32'h0000_0022, 2'b00);

    // Reset while an address is latched and data is still pending
    aw_send(16'h000C);
    check("mr_awready_busy", bus.S_AXI_AWREADY, 1'b0);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < NR; k++) exp_regs[k] = '0;
    check("mr_bvalid", bus.S_AXI_BVALID, 1'b0);
    check("mr_awready", bus.S_AXI_AWREADY, 1'b0);
    check("mr_arready", bus.S_AXI_ARREADY, 1'b0);
    check("mr_strobe", wr_strobe, 8'h00);
    check_bank("mr");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_rel_awready", bus.S_AXI_AWREADY, 1'b1);
    check("mr_rel_wready", bus.S_AXI_WREADY, 1'b1);
    // Data first: a stale latched address would commit here
    w_send(32'hCAFE_F00D, 4'b1111);
    check("mr_w_only_bvalid", bus.S_AXI_BVALID, 1'b0);
    check("mr_w_only_strobe", wr_strobe, 8'h00);
    aw_send(16'h0010);
    exp_regs[4] = 32'hCAFE_F00D;
    check("mr_post_strobe", wr_strobe, 8'h10);
    check("mr_post_bvalid", bus.S_AXI_BVALID, 1'b1);
    check_bank("mr_post");
    b_take("mr_post", 2'b00);
    rd("mr_rd4", 16'h0010, 32'hCAFE_F00D, 2'b00);
    rd("mr_rd3", 16'h000C, 32'h0000_0000, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
